addr_map_cfg: RTL and testbench

ADDR_MAP_CFG -- requirements
Module: addr_map_cfg

---
 rtl/addr_map_cfg_if.sv | 33 +++
 rtl/addr_map_cfg.sv | 131 +++++++++++++
 tb/tb_addr_map_cfg.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/addr_map_cfg_if.sv
// Rule-write and commit/status channel between a config master and addr_map_cfg.
// The slave modport is the map block; widths follow the same parameters as the block.
interface addr_map_cfg_if #(
   parameter int NoRules   = 4,
   parameter int NoIndices = 4,
   parameter int AddrWidth = 32
);
   localparam int SelWidth = (NoRules > 1) ? $clog2(NoRules) : 1;
   localparam int IdxWidth = (NoIndices > 1) ? $clog2(NoIndices) : 1;

   logic                 cfg_valid_i;
   logic                 cfg_ready_o;
   logic [SelWidth-1:0]  cfg_sel_i;
   logic                 cfg_en_i;
   logic [IdxWidth-1:0]  cfg_idx_i;
   logic [AddrWidth-1:0] cfg_start_i;
   logic [AddrWidth-1:0] cfg_end_i;
   logic                 commit_i;
   logic                 commit_done_o;
   logic                 commit_err_o;
   logic [SelWidth-1:0]  err_rule_o;
   logic                 busy_o;

   modport master (
      output cfg_valid_i, cfg_sel_i, cfg_en_i, cfg_idx_i, cfg_start_i, cfg_end_i, commit_i,
      input  cfg_ready_o, commit_done_o, commit_err_o, err_rule_o, busy_o
   );

   modport slave (
      input  cfg_valid_i, cfg_sel_i, cfg_en_i, cfg_idx_i, cfg_start_i, cfg_end_i, commit_i,
      output cfg_ready_o, commit_done_o, commit_err_o, err_rule_o, busy_o
   );
endinterface

// File: rtl/addr_map_cfg.sv
// Double-buffered address-map rules: shadow bank written over cfg, validated one slot per
// cycle on commit, then copied atomically to the active map (done after NoRules+1 or k+1 cycles).
module addr_map_cfg #(
   parameter int NoRules   = 4,
   parameter int NoIndices = 4,
   parameter int AddrWidth = 32,
   parameter int IdxWidth  = (NoIndices > 1) ? $clog2(NoIndices) : 1
) (
   input  logic                                           clk_i,
   input  logic                                           rst_i,
   addr_map_cfg_if.slave                                  cfg_if,
   output logic [NoRules-1:0][IdxWidth+2*AddrWidth-1:0]   map_o,
   output logic                                           map_valid_o
);
   localparam int SelWidth   = (NoRules > 1) ? $clog2(NoRules) : 1;
   localparam int EntryWidth = IdxWidth + 2 * AddrWidth;

   typedef struct packed {
      logic                 en;
      logic [IdxWidth-1:0]  idx;
      logic [AddrWidth-1:0] start_addr;
      logic [AddrWidth-1:0] end_addr;
   } rule_t;

   typedef enum logic [1:0] {IDLE, CHECK, APPLY} state_e;

   state_e                              state_q, state_d;
   logic [SelWidth-1:0]                 cnt_q, cnt_d;
   logic [SelWidth-1:0]                 err_rule_q, err_rule_d;
   rule_t                               shadow_q [NoRules];
   rule_t                               shadow_d [NoRules];
   logic [NoRules-1:0][EntryWidth-1:0]  map_q, map_d;
   logic                                map_valid_q, map_valid_d;
   logic                                done_q, done_d;
   logic                                err_q, err_d;

   rule_t                               cur_rule;
   logic [IdxWidth:0]                   cur_idx_ext;
   logic                                cur_fail;
   logic                                wr_en;

   always_comb begin
      wr_en       = cfg_if.cfg_valid_i && (state_q == IDLE);
      cur_rule    = shadow_q[cnt_q];
      // One spare bit so the index range test stays meaningful when NoIndices is a power of two.
      cur_idx_ext = {1'b0, cur_rule.idx};
      cur_fail    = cur_rule.en &&
                    ((cur_rule.start_addr >= cur_rule.end_addr) ||
                     (cur_idx_ext >= (IdxWidth + 1)'(NoIndices)));

      state_d     = state_q;
      cnt_d       = cnt_q;
      err_rule_d  = err_rule_q;
      shadow_d    = shadow_q;
      map_d       = map_q;
      map_valid_d = map_valid_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         IDLE: begin
            for (int i = 0; i < NoRules; i++) begin
               if (wr_en && (cfg_if.cfg_sel_i == SelWidth'(i))) begin
                  shadow_d[i] = '{en:         cfg_if.cfg_en_i,
                                  idx:        cfg_if.cfg_idx_i,
                                  start_addr: cfg_if.cfg_start_i,
                                  end_addr:   cfg_if.cfg_end_i};
               end
            end
            if (cfg_if.commit_i) begin
               state_d = CHECK;
               cnt_d   = '0;
            end
         end
         CHECK: begin
            if (cur_fail) begin
               err_rule_d = cnt_q;
               done_d     = 1'b1;
               err_d      = 1'b1;
               state_d    = IDLE;
            end else if (cnt_q == SelWidth'(NoRules - 1)) begin
               state_d = APPLY;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         APPLY: begin
            // Disabled slots present all-zero so the decoder never matches them.
            for (int i = 0; i < NoRules; i++) begin
               map_d[i] = shadow_q[i].en ?
                          {shadow_q[i].idx, shadow_q[i].start_addr, shadow_q[i].end_addr} :
                          '0;
            end
            map_valid_d = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         err_rule_q  <= '0;
         for (int i = 0; i < NoRules; i++) shadow_q[i] <= '0;
         map_q       <= '0;
         map_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_rule_q  <= err_rule_d;
         shadow_q    <= shadow_d;
         map_q       <= map_d;
         map_valid_q <= map_valid_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign cfg_if.cfg_ready_o   = (state_q == IDLE);
   assign cfg_if.busy_o        = (state_q != IDLE);
   assign cfg_if.commit_done_o = done_q;
   assign cfg_if.commit_err_o  = err_q;
   assign cfg_if.err_rule_o    = err_rule_q;
   assign map_o                = map_q;
   assign map_valid_o          = map_valid_q;
endmodule

// File: tb/tb_addr_map_cfg.sv
// Directed bench for addr_map_cfg: the driver queues expected commit outcomes, an
// independent monitor pops and compares them on every commit_done_o pulse.
module tb_addr_map_cfg;
   localparam int NR = 4;
   localparam int NI = 3;   // 3 legal targets so an out-of-range idx (3) fits in the 2-bit field
   localparam int AW = 32;

   typedef struct {
      logic         err;
      logic [1:0]   rule;
      logic [263:0] map;
      logic         valid;
      int           due;
   } exp_t;

   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic [NR-1:0][65:0] map_o;
   logic                map_valid_o;
   logic [NR-1:0][65:0] exp_map = '0;
   logic                exp_valid = 1'b0;
   exp_t                sb [$];
   int                  edge_cnt = 0;
   int                  n_cmp = 0;
   int                  n_bad = 0;

   addr_map_cfg_if #(.NoRules(NR), .NoIndices(NI), .AddrWidth(AW)) cfg_if ();

   addr_map_cfg #(.NoRules(NR), .NoIndices(NI), .AddrWidth(AW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cfg_if      (cfg_if),
      .map_o       (map_o),
      .map_valid_o (map_valid_o)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [65:0] ent(input logic [1:0] idx, input logic [31:0] s,
                                       input logic [31:0] e);
      return {idx, s, e};
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (!rst_i && cfg_if.commit_err_o && !cfg_if.commit_done_o)
            chk("err_without_done", 1'b1, 1'b0);
         if (!rst_i && cfg_if.commit_done_o) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1'b1, 1'b0);
            end else begin
               e = sb.pop_front();
               chk("done_err",   cfg_if.commit_err_o, e.err);
               chk("done_rule",  cfg_if.err_rule_o,   e.rule);
               chk("done_map",   map_o,               e.map);
               chk("done_valid", map_valid_o,         e.valid);
               chk("done_cycle", edge_cnt,            e.due);
            end
         end
      end
   end

   // All driver tasks are entered and left at a falling edge.
   task automatic write_rule(input logic [1:0] sel, input logic en, input logic [1:0] idx,
                             input logic [31:0] s, input logic [31:0] e);
      cfg_if.cfg_valid_i = 1'b1;
      cfg_if.cfg_sel_i   = sel;
      cfg_if.cfg_en_i    = en;
      cfg_if.cfg_idx_i   = idx;
      cfg_if.cfg_start_i = s;
      cfg_if.cfg_end_i   = e;
      @(negedge clk_i);
      cfg_if.cfg_valid_i = 1'b0;
   endtask

   task automatic start_commit(input logic e, input logic [1:0] r, input int lat);
      sb.push_back('{err: e, rule: r, map: exp_map, valid: exp_valid, due: edge_cnt + 1 + lat});
      cfg_if.commit_i = 1'b1;
      @(negedge clk_i);
      cfg_if.commit_i    = 1'b0;
      cfg_if.cfg_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string nm, input int exp_busy);
      int b = 0;
      while (cfg_if.busy_o && b < 40) begin
         b++;
         @(negedge clk_i);
      end
      chk({nm, "_busy_cycles"}, b, exp_busy);
      @(negedge clk_i);
   endtask

   initial begin
      cfg_if.cfg_valid_i = 1'b0;
      cfg_if.cfg_sel_i   = '0;
      cfg_if.cfg_en_i    = 1'b0;
      cfg_if.cfg_idx_i   = '0;
      cfg_if.cfg_start_i = '0;
      cfg_if.cfg_end_i   = '0;
      cfg_if.commit_i    = 1'b0;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      chk("rst_ready",    cfg_if.cfg_ready_o,   1'b1);
      chk("rst_busy",     cfg_if.busy_o,        1'b0);
      chk("rst_done",     cfg_if.commit_done_o, 1'b0);
      chk("rst_err",      cfg_if.commit_err_o,  1'b0);
      chk("rst_err_rule", cfg_if.err_rule_o,    2'd0);
      chk("rst_map",      map_o,                264'd0);
      chk("rst_valid",    map_valid_o,          1'b0);

      // Basic success, idx at its top legal value.
      write_rule(2'd0, 1'b1, 2'd2, 32'h1000, 32'h2000);
      exp_map[0] = ent(2'd2, 32'h1000, 32'h2000);
      exp_valid  = 1'b1;
      start_commit(1'b0, 2'd0, 5);
      wait_idle("c1", 5);

      // Empty range in slot 2 fails; map must stay as committed before.
      write_rule(2'd2, 1'b1, 2'd1, 32'h3000, 32'h3000);
      start_commit(1'b1, 2'd2, 3);
      wait_idle("c2", 3);

      // Out-of-range target index in slot 1 fails earlier.
      write_rule(2'd1, 1'b1, 2'd3, 32'h0100, 32'h0200);
      start_commit(1'b1, 2'd1, 2);
      wait_idle("c3", 2);

      // Disable slot 1 (junk fields masked), fix slot 2 overlapping slot 0; err_rule holds 1.
      write_rule(2'd1, 1'b0, 2'd3, 32'h0100, 32'h0200);
      write_rule(2'd2, 1'b1, 2'd0, 32'h1800, 32'h4000);
      exp_map[2] = ent(2'd0, 32'h1800, 32'h4000);
      start_commit(1'b0, 2'd1, 5);
      wait_idle("c4", 5);

      // Write and second commit during CHECK are both dropped.
      start_commit(1'b0, 2'd1, 5);
      cfg_if.cfg_valid_i = 1'b1;
      cfg_if.cfg_sel_i   = 2'd3;
      cfg_if.cfg_en_i    = 1'b1;
      cfg_if.cfg_idx_i   = 2'd1;
      cfg_if.cfg_start_i = 32'h9000;
      cfg_if.cfg_end_i   = 32'h8000;
      cfg_if.commit_i    = 1'b1;
      chk("check_ready_low", cfg_if.cfg_ready_o, 1'b0);
      @(negedge clk_i);
      cfg_if.cfg_valid_i = 1'b0;
      cfg_if.commit_i    = 1'b0;
      wait_idle("c5", 4);
      repeat (4) @(negedge clk_i);

      // Write to slot 3 in the commit cycle lands first; start=end-1 is the tightest legal range.
      cfg_if.cfg_valid_i = 1'b1;
      cfg_if.cfg_sel_i   = 2'd3;
      cfg_if.cfg_en_i    = 1'b1;
      cfg_if.cfg_idx_i   = 2'd2;
      cfg_if.cfg_start_i = 32'h5000;
      cfg_if.cfg_end_i   = 32'h5001;
      exp_map[3] = ent(2'd2, 32'h5000, 32'h5001);
      start_commit(1'b0, 2'd1, 5);
      wait_idle("c6", 5);

      // Reset in the second CHECK cycle aborts with no done pulse.
      cfg_if.commit_i = 1'b1;
      @(negedge clk_i);
      cfg_if.commit_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      chk("abort_busy",     cfg_if.busy_o,        1'b0);
      chk("abort_ready",    cfg_if.cfg_ready_o,   1'b1);
      chk("abort_done",     cfg_if.commit_done_o, 1'b0);
      chk("abort_map",      map_o,                264'd0);
      chk("abort_valid",    map_valid_o,          1'b0);
      chk("abort_err_rule", cfg_if.err_rule_o,    2'd0);
      repeat (8) @(negedge clk_i);

      // Shadow was cleared too: committing now yields an all-zero but valid map.
      exp_map   = '0;
      exp_valid = 1'b1;
      start_commit(1'b0, 2'd0, 5);
      wait_idle("c7", 5);

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
